// File: rtl/buzzer_alarm_driver.sv
// Alarm decision, hit/miss debounce and piezo tone driver for the selected sensor word.
// Define BUZZER_BEEP_PATTERN_EN for the on/off beep cadence; otherwise the tone is continuous.
module buzzer_alarm_driver #(
    parameter logic [15:0] GS_THRESH    = 16'd1000,
    parameter logic [15:0] LS_THRESH    = 16'd200,
    parameter int          HIT_COUNT    = 3,
    parameter int          TONE_DIV     = 12500,
    parameter int          BEEP_ON_CYC  = 12500000,
    parameter int          BEEP_OFF_CYC = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] selected_data,
    input  logic        buzzer_mode,
    input  logic        sample_valid,
    input  logic        mute,
    output logic        buzzer,
    output logic        alarm_active
);

    if (HIT_COUNT < 1 || HIT_COUNT > 15 || TONE_DIV < 1 ||
        BEEP_ON_CYC < 1 || BEEP_OFF_CYC < 1) begin : g_bad_cfg
        $error("buzzer_alarm_driver: parameter out of range");
    end

    localparam int              TW        = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TW-1:0]   TONE_LAST = TW'(TONE_DIV - 1);
    localparam logic [3:0]      HIT_LAST  = 4'(HIT_COUNT - 1);

`ifdef BUZZER_BEEP_PATTERN_EN
    localparam int              PMAX      = (BEEP_ON_CYC > BEEP_OFF_CYC) ? BEEP_ON_CYC : BEEP_OFF_CYC;
    localparam int              PW        = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam logic [PW-1:0]   ON_LAST   = PW'(BEEP_ON_CYC - 1);
    localparam logic [PW-1:0]   OFF_LAST  = PW'(BEEP_OFF_CYC - 1);

    typedef enum logic [1:0] {IDLE, BEEP_ON, BEEP_OFF} state_t;
    logic [PW-1:0] phase_cnt, phase_nxt;
`else
    typedef enum logic [0:0] {IDLE, BEEP_ON} state_t;
`endif

    state_t        state, state_nxt;
    logic [3:0]    hit_cnt, hit_nxt;
    logic [3:0]    miss_cnt, miss_nxt;
    logic [TW-1:0] tone_cnt, tone_nxt;
    logic          tone_q, tone_q_nxt;
    logic          mode_q;
    logic          mode_chg;
    logic          miss_clear;
    logic [16:0]   gs_mag;
    logic          is_hit;

    // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping.
    always_comb begin
        gs_mag = selected_data[15] ? (17'd0 - {1'b1, selected_data}) : {1'b0, selected_data};
        is_hit = buzzer_mode ? (selected_data < LS_THRESH) : (gs_mag > {1'b0, GS_THRESH});
    end

    assign mode_chg = (buzzer_mode != mode_q);

    always_comb begin
        state_nxt  = state;
        hit_nxt    = hit_cnt;
        miss_nxt   = miss_cnt;
        tone_nxt   = tone_cnt;
        tone_q_nxt = tone_q;
        miss_clear = 1'b0;
`ifdef BUZZER_BEEP_PATTERN_EN
        phase_nxt  = phase_cnt;
`endif
        if (mode_chg) begin
            // The sample arriving with a mode change belongs to neither rule; drop it.
            state_nxt  = IDLE;
            hit_nxt    = '0;
            miss_nxt   = '0;
            tone_nxt   = '0;
            tone_q_nxt = 1'b0;
`ifdef BUZZER_BEEP_PATTERN_EN
            phase_nxt  = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        if (!is_hit) begin
                            hit_nxt = '0;
                        end else if (hit_cnt == HIT_LAST) begin
                            state_nxt  = BEEP_ON;
                            hit_nxt    = '0;
                            tone_nxt   = '0;
                            tone_q_nxt = 1'b0;
`ifdef BUZZER_BEEP_PATTERN_EN
                            phase_nxt  = '0;
`endif
                        end else begin
                            hit_nxt = hit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    if (sample_valid) begin
                        if (is_hit)                    miss_nxt   = '0;
                        else if (miss_cnt == HIT_LAST) miss_clear = 1'b1;
                        else                           miss_nxt   = miss_cnt + 4'd1;
                    end
                    if (miss_clear) begin
                        state_nxt  = IDLE;
                        miss_nxt   = '0;
                        tone_nxt   = '0;
                        tone_q_nxt = 1'b0;
`ifdef BUZZER_BEEP_PATTERN_EN
                        phase_nxt  = '0;
`endif
                    end else if (state == BEEP_ON) begin
                        if (tone_cnt == TONE_LAST) begin
                            tone_nxt   = '0;
                            tone_q_nxt = ~tone_q;
                        end else begin
                            tone_nxt   = tone_cnt + TW'(1);
                        end
`ifdef BUZZER_BEEP_PATTERN_EN
                        if (phase_cnt == ON_LAST) begin
                            state_nxt  = BEEP_OFF;
                            phase_nxt  = '0;
                            tone_nxt   = '0;
                            tone_q_nxt = 1'b0;
                        end else begin
                            phase_nxt  = phase_cnt + PW'(1);
                        end
`endif
                    end
`ifdef BUZZER_BEEP_PATTERN_EN
                    else begin
                        // Silent phase: tone held at rest until the next beep restarts it.
                        if (phase_cnt == OFF_LAST) begin
                            state_nxt  = BEEP_ON;
                            phase_nxt  = '0;
                            tone_nxt   = '0;
                            tone_q_nxt = 1'b0;
                        end else begin
                            phase_nxt  = phase_cnt + PW'(1);
                        end
                    end
`endif
                end
            endcase
        end
    end

    // Mute only masks the pin; tone_q keeps running so unmuting resumes in phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            tone_cnt     <= '0;
            tone_q       <= 1'b0;
            mode_q       <= 1'b0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
`ifdef BUZZER_BEEP_PATTERN_EN
            phase_cnt    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            hit_cnt      <= hit_nxt;
            miss_cnt     <= miss_nxt;
            tone_cnt     <= tone_nxt;
            tone_q       <= tone_q_nxt;
            mode_q       <= buzzer_mode;
            buzzer       <= tone_q_nxt & ~mute;
            alarm_active <= (state_nxt != IDLE);
`ifdef BUZZER_BEEP_PATTERN_EN
            phase_cnt    <= phase_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_buzzer_alarm_driver.sv
// Scoreboard bench for buzzer_alarm_driver: expected alarm/buzzer per cycle from an arithmetic model.
module tb_buzzer_alarm_driver;
    localparam int TONE_DIV = 4;
    localparam int ON_CYC   = 32;
    localparam int OFF_CYC  = 16;
    localparam int HC       = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] selected_data = '0;
    logic        buzzer_mode = 1'b0;
    logic        sample_valid = 1'b0;
    logic        mute = 1'b0;
    logic        buzzer, alarm_active;

    buzzer_alarm_driver #(
        .GS_THRESH(16'd1000), .LS_THRESH(16'd200), .HIT_COUNT(HC),
        .TONE_DIV(TONE_DIV), .BEEP_ON_CYC(ON_CYC), .BEEP_OFF_CYC(OFF_CYC)
    ) dut (
        .clk(clk), .reset(reset), .selected_data(selected_data),
        .buzzer_mode(buzzer_mode), .sample_valid(sample_valid), .mute(mute),
        .buzzer(buzzer), .alarm_active(alarm_active)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int cyc; logic alarm; logic buzz; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int cyc = 0, m_start = 0, m_hit = 0, m_miss = 0;
    bit m_alarm = 0, m_mode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hit(input logic [15:0] d, input bit md);
        int v;
        if (md) return d < 16'd200;
        v = $signed(d);
        if (v < 0) v = -v;
        return v > 1000;
    endfunction

    function automatic bit tone_at(input int t);
`ifdef BUZZER_BEEP_PATTERN_EN
        int p;
        p = t % (ON_CYC + OFF_CYC);
        if (p >= ON_CYC) return 1'b0;
        return ((p / TONE_DIV) % 2) == 1;
`else
        return ((t / TONE_DIV) % 2) == 1;
`endif
    endfunction

    task automatic step(input bit v, input logic [15:0] d, input bit md, input bit mu);
        exp_t e;
        bit h;
        @(negedge clk);
        sample_valid = v; selected_data = d; buzzer_mode = md; mute = mu;
        cyc++;
        if (md != m_mode) begin
            m_mode = md; m_alarm = 0; m_hit = 0; m_miss = 0;
        end else if (v) begin
            h = is_hit(d, md);
            if (!m_alarm) begin
                if (h) begin
                    m_hit++;
                    if (m_hit == HC) begin m_alarm = 1; m_start = cyc; m_hit = 0; end
                end else m_hit = 0;
            end else begin
                if (!h) begin
                    m_miss++;
                    if (m_miss == HC) begin m_alarm = 0; m_miss = 0; end
                end else m_miss = 0;
            end
        end
        e.cyc   = cyc;
        e.alarm = m_alarm;
        e.buzz  = (m_alarm && !mu) ? tone_at(cyc - m_start) : 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'd0, m_mode, 1'b0);
    endtask

    task automatic samp(input logic [15:0] d, input bit md, input int k);
        repeat (k) step(1'b1, d, md, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("alarm@%0d", mon_e.cyc), alarm_active, mon_e.alarm);
            chk($sformatf("buzzer@%0d", mon_e.cyc), buzzer, mon_e.buzz);
        end
    end

    initial begin
        #2;
        chk("rst_alarm", alarm_active, 0);
        chk("rst_buzzer", buzzer, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic g-sensor alarm, long run covers cadence or continuous tone, then clear.
        idle(2);
        samp(16'd1500, 0, 3);
        idle(110);
        samp(16'd0, 0, 3);
        idle(3);

        // Interrupted hit run, then full-scale negative word.
        samp(16'd1500, 0, 2);
        samp(16'd500, 0, 1);
        samp(16'd1500, 0, 1);
        samp(16'd0, 0, 1);
        idle(3);
        samp(16'h8000, 0, 3);
        idle(10);
        samp(16'd0, 0, 3);
        idle(2);

        // Threshold edges in mode 0: 1000 misses, -1001 hits.
        samp(16'd1000, 0, 3);
        idle(3);
        samp(16'hFC17, 0, 3);
        idle(6);
        samp(16'd1000, 0, 3);
        idle(2);

        // Light rule, including exact threshold 200 as a miss.
        step(1'b0, 16'd0, 1'b1, 1'b0);
        idle(1);
        samp(16'd150, 1, 3);
        idle(10);
        samp(16'd250, 1, 3);
        idle(3);
        samp(16'd199, 1, 3);
        idle(5);
        samp(16'd200, 1, 3);
        idle(3);
        samp(16'd200, 1, 3);
        idle(2);

        // Mode toggle with a valid sample while alarmed: sample must be discarded.
        samp(16'd150, 1, 3);
        idle(5);
        step(1'b1, 16'd1500, 1'b0, 1'b0);
        samp(16'd1500, 0, 2);
        idle(3);
        samp(16'd1500, 0, 1);
        idle(5);

        // Mute mid-alarm, then resume in phase.
        repeat (20) step(1'b0, 16'd0, 1'b0, 1'b1);
        idle(30);
        samp(16'd0, 0, 3);
        idle(3);

        // Async reset while the tone is high.
        samp(16'd1500, 0, 3);
        idle(5);
        @(posedge clk);
        #3;
        chk("pre_rst_buzzer", buzzer, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_buzzer", buzzer, 0);
        chk("async_rst_alarm", alarm_active, 0);
        @(negedge clk);
        reset = 1'b0;
        m_alarm = 0; m_hit = 0; m_miss = 0; m_mode = 0;

        idle(3);
        samp(16'd1500, 0, 3);
        idle(8);

        @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
